// File: rtl/lb_row_scheduler.sv
// Rotates a frame's pixel rows through three line buffers and launches one conv pass per new resident row.
// Latency: buffer write 1 cycle after transfer; pass launches 2 cycles after the row-completing word.
// Backpressure: in_ready only while filling; in_valid low stalls the fill, WAIT holds until conv_done.
module lb_row_scheduler #(
    parameter int DATA_W = 24,
    parameter int ROW_W  = 800,
    parameter int ADDR_W = 10,
    parameter int IMG_H  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [2:0]        lb_wr_en,
    output logic [ADDR_W-1:0] lb_wr_addr,
    output logic [DATA_W-1:0] lb_wr_data,
    output logic              conv_valid,
    output logic [1:0]        conv_k,
    input  logic              conv_done,
    output logic              busy,
    output logic              frame_done,
    output logic [ADDR_W-1:0] pass_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_LAUNCH = 3'd2,
        S_WAIT   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] COL_LAST  = ADDR_W'(ROW_W - 1);
    // Completing pass number IMG_H-3 (0-based) finishes the frame.
    localparam logic [ADDR_W-1:0] PASS_LAST = ADDR_W'(IMG_H - 3);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] col;
    logic [1:0]        res_rows;
    logic [1:0]        wptr;
    logic [1:0]        top;
    logic              xfer;
    logic              row_end;

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    assign xfer    = in_valid & in_ready;
    assign row_end = xfer && (col == COL_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_FILL;
            S_FILL:   if (row_end && res_rows == 2'd2) state_nxt = S_LAUNCH;
            S_LAUNCH: state_nxt = S_WAIT;
            S_WAIT:   if (conv_done) state_nxt = (pass_cnt == PASS_LAST) ? S_DONE : S_FILL;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state == S_FILL);
        conv_valid = (state == S_WAIT);
        busy       = (state != S_IDLE);
        frame_done = (state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lb_wr_en   <= '0;
            lb_wr_addr <= '0;
            lb_wr_data <= '0;
            conv_k     <= '0;
            pass_cnt   <= '0;
            col        <= '0;
            res_rows   <= '0;
            wptr       <= '0;
            top        <= '0;
        end else begin
            lb_wr_en <= '0;
            if (xfer) begin
                lb_wr_en   <= 3'(3'b001 << wptr);
                lb_wr_addr <= col;
                lb_wr_data <= in_data;
                if (col == COL_LAST) begin
                    col      <= '0;
                    res_rows <= res_rows + 2'd1;
                    wptr     <= inc3(wptr);
                end else begin
                    col <= col + 1'b1;
                end
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        col      <= '0;
                        res_rows <= '0;
                        wptr     <= '0;
                        top      <= '0;
                        pass_cnt <= '0;
                    end
                end
                S_LAUNCH: conv_k <= top;
                S_WAIT: begin
                    // Oldest row is consumed; the next fill lands in the buffer just freed.
                    if (conv_done) begin
                        pass_cnt <= pass_cnt + 1'b1;
                        top      <= inc3(top);
                        res_rows <= 2'd2;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lb_row_scheduler.sv
// Randomized bench: pixel/engine traffic checked against a row- and pass-level model of the frame.
module tb_lb_row_scheduler;
    localparam int DATA_W = 24;
    localparam int ROW_W  = 8;
    localparam int ADDR_W = 10;
    localparam int IMG_H  = 6;
    localparam int NPASS  = IMG_H - 2;
    localparam int TOTAL  = IMG_H * ROW_W;
    localparam int MAXCYC = 20000;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              conv_done = 1'b0;
    logic              in_ready;
    logic [2:0]        lb_wr_en;
    logic [ADDR_W-1:0] lb_wr_addr;
    logic [DATA_W-1:0] lb_wr_data;
    logic              conv_valid;
    logic [1:0]        conv_k;
    logic              busy;
    logic              frame_done;
    logic [ADDR_W-1:0] pass_cnt;

    lb_row_scheduler #(
        .DATA_W(DATA_W), .ROW_W(ROW_W), .ADDR_W(ADDR_W), .IMG_H(IMG_H)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .lb_wr_en(lb_wr_en), .lb_wr_addr(lb_wr_addr),
        .lb_wr_data(lb_wr_data), .conv_valid(conv_valid), .conv_k(conv_k),
        .conv_done(conv_done), .busy(busy), .frame_done(frame_done), .pass_cnt(pass_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string ph);
        check({ph, "_in_ready"},   32'(in_ready),   32'd0);
        check({ph, "_lb_wr_en"},   32'(lb_wr_en),   32'd0);
        check({ph, "_lb_wr_addr"}, 32'(lb_wr_addr), 32'd0);
        check({ph, "_lb_wr_data"}, 32'(lb_wr_data), 32'd0);
        check({ph, "_conv_valid"}, 32'(conv_valid), 32'd0);
        check({ph, "_conv_k"},     32'(conv_k),     32'd0);
        check({ph, "_busy"},       32'(busy),       32'd0);
        check({ph, "_frame_done"}, 32'(frame_done), 32'd0);
        check({ph, "_pass_cnt"},   32'(pass_cnt),   32'd0);
    endtask

    // Reference state: pixels accepted in frame order, the buffer image seen on the write port,
    // and the frame/pass progress implied by the stimulus driven so far.
    logic [DATA_W-1:0] pix [TOTAL];
    logic [DATA_W-1:0] mem [3][ROW_W];
    logic [2:0]        exp_en;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    int  cyc = 0, acc = 0, done = 0, launch_at = -1, cd = 0, lim = 0;
    int  starts = 0, completed = 0, gap = 0, wa = 0;
    bit  in_frame = 0, exp_cv = 0, fd_next = 0, cur_fd = 0, wr_pend = 0, aborted = 0, ir_now = 0;

    initial begin
        rst = 1'b0; start = 1'b1; in_valid = 1'b1; in_data = 24'hABCDEF;
        repeat (3) @(negedge clk);
        check_reset("por");
        rst = 1'b1; start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("pre_start_ready", 32'(in_ready), 32'd0);
            check("pre_start_busy",  32'(busy),     32'd0);
            check("pre_start_wr",    32'(lb_wr_en), 32'd0);
        end
        in_valid = 1'b0;

        while (completed < 3 && cyc < MAXCYC) begin
            @(negedge clk);
            cyc++;
            cur_fd  = fd_next;
            fd_next = 0;
            if (cyc == launch_at) exp_cv = 1;
            lim    = (ROW_W * (3 + done) < TOTAL) ? ROW_W * (3 + done) : TOTAL;
            ir_now = in_frame && (acc < lim);

            check("in_ready",   32'(in_ready),   32'(ir_now));
            check("busy",       32'(busy),       32'(in_frame));
            check("frame_done", 32'(frame_done), 32'(cur_fd));
            check("conv_valid", 32'(conv_valid), 32'(exp_cv));
            check("pass_cnt",   32'(pass_cnt),   32'(done));
            if (wr_pend) begin
                check("wr_en",   32'(lb_wr_en),   32'(exp_en));
                check("wr_addr", 32'(lb_wr_addr), 32'(exp_addr));
                check("wr_data", 32'(lb_wr_data), 32'(exp_data));
            end else begin
                check("wr_idle", 32'(lb_wr_en), 32'd0);
            end
            wr_pend = 0;

            wa = int'(lb_wr_addr);
            if (wa < ROW_W) begin
                case (lb_wr_en)
                    3'b001:  mem[0][wa] = lb_wr_data;
                    3'b010:  mem[1][wa] = lb_wr_data;
                    3'b100:  mem[2][wa] = lb_wr_data;
                    default: ;
                endcase
            end

            // Pass p must see rows p, p+1, p+2 in buffers p%3, (p+1)%3, (p+2)%3.
            if (cyc == launch_at) begin
                check("conv_k", 32'(conv_k), 32'(done % 3));
                for (int i = 0; i < 3; i++)
                    for (int c = 0; c < ROW_W; c++)
                        check("lb_row", 32'(mem[(done + i) % 3][c]), 32'(pix[(done + i) * ROW_W + c]));
                cd = (starts == 1) ? 4 : $urandom_range(0, 6);
            end

            if (cur_fd) begin
                in_frame = 0;
                completed++;
                gap = $urandom_range(1, 4);
            end

            if (starts == 2 && !aborted && exp_cv && done == 2) begin
                aborted = 1;
                rst = 1'b0; start = 1'b0; in_valid = 1'b0; conv_done = 1'b0;
                #1;
                check_reset("abort");
                in_frame = 0; exp_cv = 0; fd_next = 0; wr_pend = 0;
                launch_at = -1; acc = 0; done = 0; gap = 1;
                repeat (2) @(negedge clk);
                rst = 1'b1;
                continue;
            end

            start = 1'b0;
            conv_done = 1'b0;
            if (!in_frame) begin
                if (gap > 0) begin
                    gap--;
                end else if (starts < 4) begin
                    start = 1'b1; in_frame = 1; acc = 0; done = 0; starts++;
                end
            end else if ($urandom_range(0, 9) == 0) begin
                start = 1'b1;
            end

            if (starts == 1) begin
                in_valid = 1'b1;
                in_data  = DATA_W'(acc);
            end else begin
                in_valid = ($urandom_range(0, 2) != 0);
                in_data  = DATA_W'($urandom);
            end
            if (in_valid && ir_now) begin
                pix[acc] = in_data;
                exp_en   = 3'(1 << ((acc / ROW_W) % 3));
                exp_addr = ADDR_W'(acc % ROW_W);
                exp_data = in_data;
                wr_pend  = 1;
                acc++;
                if (acc == lim) launch_at = cyc + 2;
            end

            if (exp_cv) begin
                if (cd == 0) begin
                    conv_done = 1'b1;
                    done++;
                    exp_cv = 0;
                    if (done == NPASS) fd_next = 1;
                end else begin
                    cd--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                conv_done = 1'b1;
            end
        end

        check("timeout",   32'(cyc < MAXCYC), 32'd1);
        check("frames",    32'(completed),    32'd3);
        check("abort_hit", 32'(aborted),      32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
